// File: rtl/dfm_pkg.sv
// Shared definitions for the frequency-meter measurement path.
//   state_e         : measurement sequencer states
//   GATE_W_DEF      : default width of gate length / timeout counters
//   TIMEOUT_CYC_DEF : default sys_clk cycles to wait for a sig edge
package dfm_pkg;

  localparam int GATE_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 24_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_GATE  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/meas_cyc_timer.sv
// Loadable up-counter with terminal-count flag.
//   clk_i, rst_i : clock, synchronous active-high reset
//   ld_i         : restart count at 0 and load terminal value ld_val_i
//   clr_i        : restart count at 0, keep terminal value
//   en_i         : count one cycle (saturates at all-ones, never wraps)
//   tc_o         : count equals the loaded terminal value
module meas_cyc_timer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_tc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_tc  <= '0;
    end else if (ld_i) begin
      r_cnt <= '0;
      r_tc  <= ld_val_i;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign tc_o = (r_cnt == r_tc);

endmodule

// File: rtl/meas_gate_ctl.sv
// Measurement sequencer for the reciprocal-counting frequency meter.
// Opens a counting gate on a sig edge, holds it for at least gate_len_i
// sys_clk cycles, closes it on the next sig edge, then strobes the regfile
// write once no SPI register read is in progress.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   en_i         : run measurements back-to-back while high
//   gate_len_i   : minimum gate length in clk_i cycles (0 behaves as 1)
//   sig_edge_i   : one-cycle pulse per sig_clk rising edge (synchronised)
//   rd_busy_i    : SPI register read in progress, blocks the write strobe
//   cnt_clr_o    : one-cycle clear for the measure counters
//   cnt_en_o     : counter enable (the gate)
//   reg_wr_en_o  : one-cycle regfile write strobe
//   busy_o       : sequencer not idle
//   err_o        : last written measurement timed out
//
// state | meaning
// IDLE  | stopped, waiting for en_i
// ARM   | counters cleared, waiting for the opening sig edge
// GATE  | gate open, minimum length not yet elapsed
// CLOSE | minimum length elapsed, gate open until the closing sig edge
// WRITE | gate shut, waiting for rd_busy_i low to strobe the regfile
module meas_gate_ctl
  import dfm_pkg::*;
#(
  parameter int GATE_W      = GATE_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic              sig_edge_i,
  input  logic              rd_busy_i,
  output logic              cnt_clr_o,
  output logic              cnt_en_o,
  output logic              reg_wr_en_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [GATE_W-1:0] LEN_ONE = GATE_W'(1);
  localparam logic [GATE_W-1:0] TO_TC   = GATE_W'(TIMEOUT_CYC - 1);

  state_e r_state;
  logic   r_cnt_clr;
  logic   r_cnt_en;
  logic   r_reg_wr;
  logic   r_busy;
  logic   r_err;
  logic   r_err_pend;

  logic              w_arm_entry;
  logic              w_gate_open;
  logic              w_close_entry;
  logic              w_gate_tc;
  logic              w_to_tc;
  logic [GATE_W-1:0] w_len_tc;

  // Terminal value is len-1 because the timer reads 0 in the first gate
  // cycle; a zero length collapses onto the one-cycle minimum gate.
  assign w_len_tc = (gate_len_i == '0) ? '0 : (gate_len_i - LEN_ONE);

  assign w_arm_entry   = en_i && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_WRITE) && !rd_busy_i));
  assign w_gate_open   = (r_state == ST_ARM) && en_i && sig_edge_i;
  assign w_close_entry = (r_state == ST_GATE) && en_i && w_gate_tc && !sig_edge_i;

  meas_cyc_timer #(.W(GATE_W)) u_gate_tmr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     (w_arm_entry),
    .ld_val_i (w_len_tc),
    .clr_i    (w_gate_open),
    .en_i     (r_state == ST_GATE),
    .tc_o     (w_gate_tc)
  );

  // One timer covers both the opening-edge wait (ARM) and the closing-edge
  // wait (CLOSE); it is restarted on entry to either.
  meas_cyc_timer #(.W(GATE_W)) u_to_tmr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     (w_arm_entry || w_close_entry),
    .ld_val_i (TO_TC),
    .clr_i    (1'b0),
    .en_i     ((r_state == ST_ARM) || (r_state == ST_CLOSE)),
    .tc_o     (w_to_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt_clr  <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_cnt_clr <= 1'b0;
      r_reg_wr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en_i) begin
            r_state   <= ST_ARM;
            r_cnt_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_ARM: begin
          if (!en_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (sig_edge_i) begin
            // Opening edge falls before the enable, so it is not counted.
            r_state  <= ST_GATE;
            r_cnt_en <= 1'b1;
          end else if (w_to_tc) begin
            r_state    <= ST_WRITE;
            r_err_pend <= 1'b1;
          end
        end
        ST_GATE: begin
          if (!en_i) begin
            r_state  <= ST_IDLE;
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_gate_tc) begin
            if (sig_edge_i) begin
              r_state    <= ST_WRITE;
              r_cnt_en   <= 1'b0;
              r_err_pend <= 1'b0;
            end else begin
              r_state <= ST_CLOSE;
            end
          end
        end
        ST_CLOSE: begin
          if (!en_i) begin
            r_state  <= ST_IDLE;
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
          end else if (sig_edge_i) begin
            // Enable is still high this cycle, so the closing edge counts.
            r_state    <= ST_WRITE;
            r_cnt_en   <= 1'b0;
            r_err_pend <= 1'b0;
          end else if (w_to_tc) begin
            r_state    <= ST_WRITE;
            r_cnt_en   <= 1'b0;
            r_err_pend <= 1'b1;
          end
        end
        ST_WRITE: begin
          // rd_busy_i is sampled at this edge; a read starting in the
          // strobe cycle itself arrives too late to block it.
          if (!rd_busy_i) begin
            r_reg_wr <= 1'b1;
            r_err    <= r_err_pend;
            if (en_i) begin
              r_state   <= ST_ARM;
              r_cnt_clr <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_clr_o   = r_cnt_clr;
  assign cnt_en_o    = r_cnt_en;
  assign reg_wr_en_o = r_reg_wr;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_meas_gate_ctl.sv
module tb_meas_gate_ctl;

  localparam int GW = 32;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [GW-1:0] gate_len;
  logic          sig_edge;
  logic          rd_busy;
  logic          cnt_clr;
  logic          cnt_en;
  logic          reg_wr;
  logic          busy;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sig_period = 0;
  int ph       = 0;

  typedef struct {
    bit err;
    int win;
    int edges;
  } exp_t;

  exp_t exp_q[$];

  meas_gate_ctl #(.GATE_W(GW), .TIMEOUT_CYC(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .gate_len_i  (gate_len),
    .sig_edge_i  (sig_edge),
    .rd_busy_i   (rd_busy),
    .cnt_clr_o   (cnt_clr),
    .cnt_en_o    (cnt_en),
    .reg_wr_en_o (reg_wr),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Periodic sig edge source; period 0 means no input signal.
  initial begin
    sig_edge = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sig_period > 0) begin
        ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
        sig_edge = (ph == 0);
      end else begin
        ph = 0;
        sig_edge = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // which: 0 = cnt_clr, 1 = reg_wr_en, 2 = cnt_en
  task automatic wait_out(input int which, input int budget, input string nm, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && cnt_clr) || (which == 1 && reg_wr) || (which == 2 && cnt_en)) begin
        c = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: output not seen within %0d cycles", nm, budget);
  endtask

  // Scoreboard monitor: measures each gate window and checks it on the strobe.
  initial begin : mon
    exp_t e;
    int win;
    int edg;
    win = 0;
    edg = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        win = 0;
        edg = 0;
      end else begin
        if (reg_wr) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe: strobe at cycle %0d with nothing expected", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_err", int'(err), int'(e.err));
            chk("window_cycles", win, e.win);
            chk("window_edges", edg, e.edges);
          end
        end
        if (cnt_clr) begin
          win = 0;
          edg = 0;
        end
        if (cnt_en) begin
          win++;
          if (sig_edge) edg++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   c1;
    logic ok;
    rst = 1'b1; en = 1'b0; gate_len = '0; rd_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_cnt_en", int'(cnt_en), 0);
    chk("rst_reg_wr", int'(reg_wr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);

    // Basic gate: len 100, period 7 -> 15 edges over 105 cycles.
    @(posedge clk); #1;
    gate_len = 100; sig_period = 7; exp_q.push_back('{1'b0, 105, 15}); en = 1'b1;
    wait_out(0, 5, "basic_clr", c0);
    @(negedge clk);
    chk("basic_clr_single", int'(cnt_clr), 0);
    chk("basic_busy", int'(busy), 1);
    wait_out(1, 400, "basic_strobe", c1);
    chk("b2b_rearm_clr", int'(cnt_clr), 1);
    chk("b2b_busy", int'(busy), 1);
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(negedge clk);
    chk("stop_busy", int'(busy), 0);

    // Expiry coincides with an edge: len 14, period 7 -> 2 edges, 14 cycles.
    @(posedge clk); #1;
    gate_len = 14; exp_q.push_back('{1'b0, 14, 2}); en = 1'b1;
    wait_out(1, 100, "simul_strobe", c1);
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(negedge clk);

    // Read hold-off spanning WRITE entry.
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 14, 2}); en = 1'b1;
    wait_out(2, 50, "hold_gate_open", c0);
    @(posedge clk); #1 rd_busy = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (reg_wr) ok = 1'b0;
    end
    chk("hold_no_strobe", int'(ok), 1);
    chk("hold_cnt_en_low", int'(cnt_en), 0);
    chk("hold_busy", int'(busy), 1);
    @(posedge clk); #1 rd_busy = 1'b0;
    @(negedge clk);
    chk("hold_strobe_not_early", int'(reg_wr), 0);
    @(negedge clk);
    chk("hold_strobe_latency", int'(reg_wr), 1);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    chk("hold_single_strobe", int'(reg_wr), 0);
    @(negedge clk);

    // No signal: timeout after TO cycles in ARM.
    @(posedge clk); #1;
    sig_period = 0; exp_q.push_back('{1'b1, 0, 0}); en = 1'b1;
    wait_out(0, 5, "to_clr", c0);
    wait_out(1, TO + 20, "to_strobe", c1);
    chk("to_latency", c1 - c0, TO + 1);
    chk("to_err", int'(err), 1);
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(negedge clk);

    // Abort mid-GATE: no write, err unchanged.
    @(posedge clk); #1;
    sig_period = 7; gate_len = 100; en = 1'b1;
    wait_out(2, 50, "abort_gate_open", c0);
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    chk("abort_still_gate", int'(cnt_en), 1);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cnt_en", int'(cnt_en), 0);
    chk("abort_err_kept", int'(err), 1);
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (reg_wr) ok = 1'b0;
    end
    chk("abort_no_strobe", int'(ok), 1);

    // Valid measurements back-to-back clear err.
    @(posedge clk); #1;
    gate_len = 14;
    exp_q.push_back('{1'b0, 14, 2});
    exp_q.push_back('{1'b0, 14, 2});
    en = 1'b1;
    wait_out(1, 100, "valid1_strobe", c0);
    chk("valid_err_cleared", int'(err), 0);
    wait_out(1, 100, "valid2_strobe", c1);
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(negedge clk);

    // Set err again so reset visibly clears it.
    @(posedge clk); #1;
    sig_period = 0; exp_q.push_back('{1'b1, 0, 0}); en = 1'b1;
    wait_out(1, TO + 20, "to2_strobe", c1);
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in CLOSE (cycles 101..105 of the gate).
    @(posedge clk); #1;
    sig_period = 7; gate_len = 100; en = 1'b1;
    wait_out(2, 50, "rst_gate_open", c0);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("rst_in_close", int'(cnt_en), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_cnt_clr", int'(cnt_clr), 0);
    chk("midrst_cnt_en", int'(cnt_en), 0);
    chk("midrst_reg_wr", int'(reg_wr), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (reg_wr) ok = 1'b0;
    end
    chk("midrst_no_strobe", int'(ok), 1);

    // Zero length behaves as a one-cycle gate.
    @(posedge clk); #1;
    gate_len = 0; sig_period = 1; exp_q.push_back('{1'b0, 1, 1}); en = 1'b1;
    wait_out(1, 20, "len0_strobe", c1);
    @(posedge clk); #1 en = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
